// File: rtl/smc_bridge_pkg.sv
// Shared definitions for the SMC AHB-lite to APB bridge: FSM states,
// AHB transfer/response codes and the register window geometry.
package smc_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Window: haddr[PADDR_W +: WIN_HI_BITS] must be zero; offsets live below PADDR_W.
    localparam int PADDR_W         = 5;
    localparam int WIN_HI_BITS_DEF = 7;

endpackage

// File: rtl/smc_ahb_apb_bridge.sv
// AHB-lite slave to APB master bridge for the SMC register block.
// Legal word accesses inside the 32-byte window take SETUP+ACCESS; others get a two-cycle ERROR.
module smc_ahb_apb_bridge
    import smc_bridge_pkg::*;
#(
    parameter int WIN_HI_BITS = WIN_HI_BITS_DEF
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                hsel,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [31:0]         haddr,
    input  logic [31:0]         hwdata,
    input  logic                hready_in,
    output logic                hready_out,
    output logic [1:0]          hresp,
    output logic [31:0]         hrdata,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [PADDR_W-1:0]  paddr,
    output logic [31:0]         pwdata,
    input  logic [31:0]         prdata
);

    state_t state;
    logic   active;
    logic   accept;
    logic   legal;
    logic   unused_haddr;

    assign unused_haddr = ^haddr;

    assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign accept = hsel && active && hready_in && hready_out;
    assign legal  = (haddr[PADDR_W +: WIN_HI_BITS] == '0) && (hsize == HSIZE_WORD);

    // paddr/pwrite only load on a legal accept, so an address phase overlapping
    // ACCESS cannot disturb the transfer in flight, and errors leave them untouched.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state  <= ST_IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: state <= ST_ACCESS;
                ST_ERR1:  state <= ST_ERR2;
                default: begin
                    if (accept) begin
                        if (legal) begin
                            state  <= ST_SETUP;
                            paddr  <= haddr[PADDR_W-1:0];
                            pwrite <= hwrite;
                        end else begin
                            state <= ST_ERR1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwdata     = '0;
        case (state)
            ST_SETUP: begin
                psel       = 1'b1;
                hready_out = 1'b0;
                pwdata     = hwdata;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwdata  = hwdata;
                hrdata  = prdata;
            end
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_smc_ahb_apb_bridge.sv
// Bench for smc_ahb_apb_bridge: directed scenarios with literal expectations,
// then randomized AHB traffic checked every cycle against a transfer-level model.
module tb_smc_ahb_apb_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    int n_vec = 0;
    int n_err = 0;

    smc_ahb_apb_bridge dut (
        .pclk(pclk), .preset(preset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in),
        .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: which data phase is open (none / ok / error) and
    // whether it is in its first (wait) or second (completing) cycle.
    int         m_kind;   // 0 none, 1 legal APB transfer, 2 error response
    int         m_cyc;
    logic [4:0] m_paddr;
    logic       m_pwrite;

    function automatic bit m_ready();
        return !(m_kind != 0 && m_cyc == 0);
    endfunction

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_kind <= 0; m_cyc <= 0; m_paddr <= '0; m_pwrite <= 1'b0;
        end else if (hsel && htrans[1] && hready_in && m_ready()) begin
            if (haddr[11:5] == 7'd0 && hsize == 3'b010) begin
                m_kind <= 1; m_paddr <= haddr[4:0]; m_pwrite <= hwrite;
            end else begin
                m_kind <= 2;
            end
            m_cyc <= 0;
        end else if (m_kind != 0 && m_cyc == 0) begin
            m_cyc <= 1;
        end else begin
            m_kind <= 0;
        end
    end

    always @(negedge pclk) begin
        if (!preset) begin
            chk("m_hready_out", hready_out, m_ready());
            chk("m_hresp", hresp, (m_kind == 2) ? 32'd1 : 32'd0);
            chk("m_psel", psel, m_kind == 1);
            chk("m_penable", penable, m_kind == 1 && m_cyc == 1);
            chk("m_hrdata", hrdata, (m_kind == 1 && m_cyc == 1) ? prdata : 32'd0);
            chk("m_pwdata", pwdata, (m_kind == 1) ? hwdata : 32'd0);
            chk("m_paddr", paddr, m_paddr);
            chk("m_pwrite", pwrite, m_pwrite);
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = '0;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    initial begin
        preset = 1'b1; bus_idle(); hwdata = '0; hready_in = 1'b1; prdata = '0;
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_hready", hready_out, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        @(posedge pclk); #1 preset = 1'b0;

        // Word write at the first edge after reset
        addr_phase(1'b1, 32'h0, 3'b010);
        step();
        bus_idle(); hwdata = 32'hA5A5_0001; #1;
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_hready", hready_out, 0);
        chk("wr_setup_paddr", paddr, 0);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
        step();
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_access_hready", hready_out, 1);
        chk("wr_access_hresp", hresp, 0);
        step();
        chk("wr_done_psel", psel, 0);
        chk("wr_done_pwdata", pwdata, 0);

        // Word read
        prdata = 32'h1234_5678;
        addr_phase(1'b0, 32'h0, 3'b010);
        step(); bus_idle(); #1;
        chk("rd_setup_hrdata", hrdata, 0);
        chk("rd_setup_hready", hready_out, 0);
        step();
        chk("rd_access_hrdata", hrdata, 32'h1234_5678);
        chk("rd_access_hready", hready_out, 1);
        step();
        chk("rd_done_hrdata", hrdata, 0);

        // Back-to-back write 0x04 then read 0x08
        addr_phase(1'b1, 32'h4, 3'b010);
        step();
        addr_phase(1'b0, 32'h8, 3'b010); hwdata = 32'hCAFE_0004; #1;
        chk("b2b_setup1_paddr", paddr, 5'h04);
        step();
        chk("b2b_access1_paddr", paddr, 5'h04);
        chk("b2b_access1_penable", penable, 1);
        step(); bus_idle(); #1;
        chk("b2b_setup2_psel", psel, 1);
        chk("b2b_setup2_penable", penable, 0);
        chk("b2b_setup2_paddr", paddr, 5'h08);
        chk("b2b_setup2_pwrite", pwrite, 0);
        step();
        chk("b2b_access2_paddr", paddr, 5'h08);
        chk("b2b_access2_penable", penable, 1);
        step();

        // Out-of-window read, then halfword write
        for (int k = 0; k < 2; k++) begin
            if (k == 0) addr_phase(1'b0, 32'h20, 3'b010);
            else        addr_phase(1'b1, 32'h0, 3'b001);
            step(); bus_idle(); #1;
            chk("err1_hready", hready_out, 0);
            chk("err1_hresp", hresp, 1);
            chk("err1_psel", psel, 0);
            step();
            chk("err2_hready", hready_out, 1);
            chk("err2_hresp", hresp, 1);
            chk("err2_psel", psel, 0);
            chk("err2_paddr_hold", paddr, 5'h08);
            step();
        end

        // Reset during SETUP, then a normal read
        addr_phase(1'b1, 32'hC, 3'b010);
        step(); bus_idle(); #1;
        chk("rstmid_setup_psel", psel, 1);
        preset = 1'b1; #1;
        chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_hready", hready_out, 1);
        @(posedge pclk); #1 preset = 1'b0;
        prdata = 32'h0BAD_F00D;
        addr_phase(1'b0, 32'h10, 3'b010);
        step(); bus_idle(); #1;
        chk("post_rst_paddr", paddr, 5'h10);
        step();
        chk("post_rst_hrdata", hrdata, 32'h0BAD_F00D);
        step();

        // BUSY with hsel=1, then NONSEQ with hsel=0: nothing happens
        for (int k = 0; k < 10; k++) begin
            hsel = (k < 5); htrans = (k < 5) ? 2'b01 : 2'b10; haddr = 32'h4;
            step();
            chk("ignore_psel", psel, 0);
            chk("ignore_hready", hready_out, 1);
            chk("ignore_hresp", hresp, 0);
        end
        bus_idle();

        // Randomized traffic, checked by the per-cycle model compare
        for (int k = 0; k < 3000; k++) begin
            step();
            hsel      = ($urandom_range(0, 3) != 0);
            htrans    = 2'($urandom);
            hwrite    = 1'($urandom);
            hsize     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            haddr     = ($urandom_range(0, 7) == 0) ? $urandom : {27'd0, 5'($urandom)};
            hready_in = ($urandom_range(0, 9) != 0);
            hwdata    = $urandom;
            prdata    = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                preset = 1'b1; #2 preset = 1'b0;
            end
        end
        step(); bus_idle();
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smc_ahb_apb_bridge.md
SMC_AHB_APB_BRIDGE -- requirements
Module: smc_ahb_apb_bridge

Interface
REQ-001 Parameter WIN_HI_BITS, default 7: haddr[11:5] must equal zero for an access to be in-window; in-window offsets are 0x00-0x1F.
REQ-002 Clocking: one clock, pclk; reset preset is asynchronous and active-high.
REQ-003 pclk  in  1  clock for both the AHB-lite and APB sides.
REQ-004 preset  in  1  asynchronous reset, active-high.
REQ-005 hsel  in  1  AHB slave select.
REQ-006 htrans  in  2  AHB transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 hwrite  in  1  AHB write (1) / read (0).
REQ-008 hsize  in  3  AHB transfer size; only 3'b010 (word) is legal.
REQ-009 haddr  in  32  AHB address.
REQ-010 hwdata  in  32  AHB write data, valid in the data phase.
REQ-011 hready_in  in  1  AHB bus-wide ready.
REQ-012 hready_out  out  1  slave ready.
REQ-013 hresp  out  2  response; OKAY=00, ERROR=01.
REQ-014 hrdata  out  32  read data.
REQ-015 psel  out  1  APB select.
REQ-016 penable  out  1  APB enable.
REQ-017 pwrite  out  1  APB write strobe.
REQ-018 paddr  out  5  APB address.
REQ-019 pwdata  out  32  APB write data.
REQ-020 prdata  in  32  APB read data from the SMC register interface.

Function
REQ-021 Accept: a transfer is accepted at a pclk edge where hsel=1, htrans[1]=1, hready_in=1 and hready_out=1; haddr[4:0], haddr[11:5], hwrite and hsize are registered at that edge.
REQ-022 BUSY and IDLE htrans values, and cycles with hsel=0, shall be ignored with no state change; hready_out stays 1 and hresp stays OKAY.
REQ-023 State machine: IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-024 IDLE or ACCESS, on accept: go to SETUP if the access is legal (in-window and word size); otherwise go to ERR1.
REQ-025 IDLE or ACCESS, with no accept: go to IDLE.
REQ-026 SETUP: psel=1, penable=0, hready_out=0; paddr and pwrite come from the registered values; next state ACCESS unconditionally.
REQ-027 ACCESS: psel=1, penable=1, hready_out=1, hrdata=prdata (combinational); the AHB data phase completes at the end of ACCESS.
REQ-028 Latency: every legal transfer takes exactly 2 data-phase cycles (1 wait state).
REQ-029 Back-to-back: an accept at the end of ACCESS goes directly to SETUP with no IDLE cycle; psel stays 1 and penable returns to 0.
REQ-030 pwdata shall equal hwdata combinationally during SETUP and ACCESS; AHB holds hwdata stable while hready_out=0; pwdata is 0 otherwise.
REQ-031 ERR1: hready_out=0, hresp=ERROR, psel=0; next state ERR2.
REQ-032 ERR2: hready_out=1, hresp=ERROR; accepts are honoured as in IDLE.
REQ-033 Illegal accesses shall never assert psel.
REQ-034 hresp shall be OKAY in IDLE, SETUP and ACCESS.
REQ-035 hrdata shall be 0 outside ACCESS.
REQ-036 paddr and pwrite hold their last value while psel=0.
REQ-037 Simultaneous events: the AHB address phase and the APB ACCESS overlap legally; the new address is registered without corrupting the paddr of the ongoing ACCESS until the following SETUP.

Reset
REQ-038 On preset=1, asynchronously: state=IDLE, psel=0, penable=0, hready_out=1, hresp=OKAY, paddr=0, pwrite=0; any in-flight transfer is abandoned.
REQ-039 The first accept shall be possible at the first pclk edge after preset deasserts.

Structure
REQ-040 Shared package smc_bridge_pkg shall hold: the state enum, HTRANS and HRESP codes, the word hsize code and the window constant.
REQ-041 The block is a single module with no sub-module: one state register plus an address/control capture register, with combinational outputs decoded from state.

Verification
REQ-042 Write 0xA5A5_0001 to haddr 0x0000_0000 -> psel high 2 cycles, penable high in the 2nd, paddr=0, pwrite=1, pwdata=0xA5A5_0001, hready_out low exactly 1 cycle, hresp OKAY.
REQ-043 Read haddr 0x0000_0000 with prdata=0x1234_5678 -> hrdata=0x1234_5678 while hready_out=1 in ACCESS, total 2 data-phase cycles.
REQ-044 Back-to-back NONSEQ write to 0x04 then read from 0x08 -> SETUP,ACCESS,SETUP,ACCESS with no gap, paddr 0x04 then 0x08.
REQ-045 Read haddr 0x0000_0020, or a halfword write to 0x00 -> ERROR response across 2 cycles (hready_out 0 then 1), psel never asserted.
REQ-046 preset pulsed during SETUP -> psel/penable drop the same cycle, hready_out=1; the next transfer completes normally.
REQ-047 htrans=BUSY or hsel=0 for 5 cycles -> no APB activity; hready_out=1 and hresp=OKAY throughout.
